// File: rtl/rx_abort_watchdog_pkg.sv
// Shared definitions for the receiver abort watchdog.
// Covers cause bit positions, the episode FSM encoding and the equalizer small-magnitude limit.
package rx_abort_watchdog_pkg;

  localparam int NUM_CAUSES    = 4;
  localparam int CAUSE_LEN     = 0;
  localparam int CAUSE_DC      = 1;
  localparam int CAUSE_EQ      = 2;
  localparam int CAUSE_TIMEOUT = 3;

  // An equalizer tap counts as "small" when both |I| and |Q| are below this value.
  localparam int EQ_SMALL_MAG  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_BLANK = 2'd2
  } wd_state_e;

endpackage

// File: rtl/rx_wd_dc_monitor.sv
// DC-bias detector: accumulates the sign of I samples over a window of 2^WIN_LOG2 samples.
// It raises dc_raise on the closing sample when the magnitude of the sign sum exceeds dc_th.
module rx_wd_dc_monitor #(
  parameter int WIN_LOG2 = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       sample_valid,
  input  logic       sample_neg,
  input  logic [7:0] dc_th,
  output logic       dc_raise
);

  localparam int SW = WIN_LOG2 + 1;
  localparam int CW = (SW + 1 > 8) ? SW + 1 : 8;

  logic signed [SW-1:0]   sum_q;
  logic [WIN_LOG2-1:0]    idx_q;
  logic signed [SW:0]     step_v;
  logic signed [SW:0]     sum_final;
  logic [SW:0]            sum_abs;
  logic                   window_end;

  // The registered sum never holds more than 2^WIN_LOG2-1 samples; the closing
  // sample is folded in one bit wider so a full +/-2^WIN_LOG2 window is exact.
  assign step_v     = sample_neg ? {(SW+1){1'b1}} : (SW+1)'(1);
  assign sum_final  = $signed({sum_q[SW-1], sum_q}) + step_v;
  assign sum_abs    = sum_final[SW] ? (SW+1)'(-sum_final) : (SW+1)'(sum_final);
  assign window_end = sample_valid && (idx_q == '1);
  assign dc_raise   = window_end && (CW'(sum_abs) > CW'(dc_th));

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sum_q <= '0;
      idx_q <= '0;
    end else if (sample_valid) begin
      idx_q <= idx_q + 1'b1;
      sum_q <= window_end ? '0 : sum_final[SW-1:0];
    end
  end

endmodule

// File: rtl/rx_abort_watchdog.sv
// Receiver abort watchdog: watches DC bias, SIGNAL length, equalizer collapse and state stalls,
// pulses receiver_rst and counts aborts per cause. Define RX_ABORT_WATCHDOG_TIMEOUT_EN for the stall detector.
module rx_abort_watchdog
  import rx_abort_watchdog_pkg::*;
#(
  parameter int IQ_DATA_WIDTH = 16,
  parameter int DC_WIN_LOG2   = 6,
  parameter int CNT_WIDTH     = 16,
  parameter int RST_HOLD      = 2,
  parameter int BLANK_CYCLES  = 16
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic                            enable,
  input  logic                            power_trigger,
  input  logic signed [IQ_DATA_WIDTH-1:0] i_data,
  input  logic signed [IQ_DATA_WIDTH-1:0] q_data,
  input  logic                            iq_valid,
  input  logic [4:0]                      state,
  input  logic                            sig_valid,
  input  logic [15:0]                     signal_len,
  input  logic [31:0]                     equalizer,
  input  logic                            equalizer_valid,
  input  logic [3:0]                      min_len_th,
  input  logic [15:0]                     max_len_th,
  input  logic [7:0]                      dc_th,
  input  logic [5:0]                      small_eq_th,
  input  logic [15:0]                     timeout_th,
  input  logic                            cnt_clear,
  output logic                            receiver_rst,
  output logic [NUM_CAUSES-1:0]           cause_vec,
  output logic [NUM_CAUSES*CNT_WIDTH-1:0] abort_cnt,
  output logic                            busy
);

  localparam int TMR_MAX = (RST_HOLD > BLANK_CYCLES) ? RST_HOLD : BLANK_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic signed [15:0] EQ_POS = 16'(EQ_SMALL_MAG);
  localparam logic signed [15:0] EQ_NEG = -EQ_POS;

  wd_state_e                             fsm_q;
  logic [TMR_W-1:0]                      tmr_q;
  logic [NUM_CAUSES-1:0][CNT_WIDTH-1:0]  cnt_q;
  logic [5:0]                            eq_cnt_q;
  logic signed [15:0]                    eq_i, eq_q;
  logic                                  eq_small;
  logic                                  len_raise, dc_raise, eq_raise, to_raise;
  logic [NUM_CAUSES-1:0]                 raw, raised;
  logic                                  go_hold, det_clear;
  logic                                  unused_inputs;

  assign len_raise = sig_valid &&
                     ((signal_len < {12'd0, min_len_th}) || (signal_len > max_len_th));

  assign eq_i     = equalizer[31:16];
  assign eq_q     = equalizer[15:0];
  assign eq_small = (eq_i > EQ_NEG) && (eq_i < EQ_POS) && (eq_q > EQ_NEG) && (eq_q < EQ_POS);
  assign eq_raise = (small_eq_th != '0) && (eq_cnt_q >= small_eq_th);

  // NOTE: always_comb assigns a default first so no path leaves raw undriven (no latch).
  always_comb begin
    raw                = '0;
    raw[CAUSE_LEN]     = len_raise;
    raw[CAUSE_DC]      = dc_raise;
    raw[CAUSE_EQ]      = eq_raise;
    raw[CAUSE_TIMEOUT] = to_raise;
  end

  assign raised    = enable ? raw : '0;
  assign go_hold   = (fsm_q == ST_IDLE) && power_trigger && (|raised);
  assign det_clear = !enable || go_hold;
  assign abort_cnt = cnt_q;

  rx_wd_dc_monitor #(
    .WIN_LOG2(DC_WIN_LOG2)
  ) u_dc_monitor (
    .clk          (s00_axi_aclk),
    .rst_n        (s00_axi_aresetn),
    .clear        (det_clear),
    .sample_valid (iq_valid),
    .sample_neg   (i_data[IQ_DATA_WIDTH-1]),
    .dc_th        (dc_th),
    .dc_raise     (dc_raise)
  );

`ifdef RX_ABORT_WATCHDOG_TIMEOUT_EN
  logic [4:0]  prev_state_q;
  logic [15:0] to_cnt_q, to_run;

  // to_run is the number of cycles the current nonzero state has already been held.
  always_comb begin
    to_run = '0;
    if (state != '0 && state == prev_state_q)
      to_run = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 16'd1;
  end

  assign to_raise = (timeout_th != '0) && (to_run == timeout_th);

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      prev_state_q <= '0;
      to_cnt_q     <= '0;
    end else begin
      prev_state_q <= state;
      to_cnt_q     <= det_clear ? '0 : to_run;
    end
  end

  assign unused_inputs = ^{q_data, i_data[IQ_DATA_WIDTH-2:0]};
`else
  assign to_raise      = 1'b0;
  assign unused_inputs = ^{q_data, i_data[IQ_DATA_WIDTH-2:0], state, timeout_th};
`endif

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn || det_clear) begin
      eq_cnt_q <= '0;
    end else if (equalizer_valid && eq_small && eq_cnt_q != '1) begin
      eq_cnt_q <= eq_cnt_q + 6'd1;
    end
  end

  // A clear in the same cycle as an abort wins over the increment.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn || cnt_clear) begin
      cnt_q <= '0;
    end else if (go_hold) begin
      for (int c = 0; c < NUM_CAUSES; c++)
        if (raised[c] && cnt_q[c] != '1) cnt_q[c] <= cnt_q[c] + 1'b1;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      fsm_q        <= ST_IDLE;
      tmr_q        <= '0;
      receiver_rst <= 1'b0;
      busy         <= 1'b0;
      cause_vec    <= '0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (go_hold) begin
            fsm_q        <= ST_HOLD;
            tmr_q        <= '0;
            receiver_rst <= 1'b1;
            busy         <= 1'b1;
            cause_vec    <= raised;
          end
        end
        ST_HOLD: begin
          if (tmr_q == TMR_W'(RST_HOLD - 1)) begin
            fsm_q        <= ST_BLANK;
            tmr_q        <= '0;
            receiver_rst <= 1'b0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        ST_BLANK: begin
          if (tmr_q == TMR_W'(BLANK_CYCLES - 1)) begin
            fsm_q <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        default: begin
          fsm_q        <= ST_IDLE;
          receiver_rst <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_abort_watchdog.sv
// Testbench for rx_abort_watchdog: directed scenarios followed by random traffic, every cycle
// compared against a cycle-level reference model; honours RX_ABORT_WATCHDOG_TIMEOUT_EN.
module tb_rx_abort_watchdog;

  localparam int W       = 16;
  localparam int DC_WIN  = 64;
  localparam int CW      = 16;
  localparam int HOLD_N  = 2;
  localparam int BLANK_N = 16;
  localparam int CNT_MAX = 65535;

`ifdef RX_ABORT_WATCHDOG_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable, power_trigger, iq_valid, sig_valid, equalizer_valid, cnt_clear;
  logic signed [W-1:0] i_data, q_data;
  logic [4:0]        state;
  logic [15:0]       signal_len, max_len_th, timeout_th;
  logic [31:0]       equalizer;
  logic [3:0]        min_len_th;
  logic [7:0]        dc_th;
  logic [5:0]        small_eq_th;
  logic              receiver_rst, busy;
  logic [3:0]        cause_vec;
  logic [4*CW-1:0]   abort_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: an episode is a countdown of HOLD_N+BLANK_N cycles.
  int m_left, m_dc_sum, m_dc_n, m_eq, m_to, m_prev;
  int m_cnt[4];
  logic [3:0] m_cause;

  always #5 clk = ~clk;

  rx_abort_watchdog dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .enable          (enable),
    .power_trigger   (power_trigger),
    .i_data          (i_data),
    .q_data          (q_data),
    .iq_valid        (iq_valid),
    .state           (state),
    .sig_valid       (sig_valid),
    .signal_len      (signal_len),
    .equalizer       (equalizer),
    .equalizer_valid (equalizer_valid),
    .min_len_th      (min_len_th),
    .max_len_th      (max_len_th),
    .dc_th           (dc_th),
    .small_eq_th     (small_eq_th),
    .timeout_th      (timeout_th),
    .cnt_clear       (cnt_clear),
    .receiver_rst    (receiver_rst),
    .cause_vec       (cause_vec),
    .abort_cnt       (abort_cnt),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_small(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    return (s > -16) && (s < 16);
  endfunction

  function automatic logic [63:0] exp_cnt();
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < 4; c++) v[16*c +: 16] = 16'(m_cnt[c]);
    return v;
  endfunction

  function automatic void model_step();
    logic [3:0] c;
    int s_next, s_abs, run;
    bit win_end, fire;
    if (!rst_n) begin
      m_left = 0; m_dc_sum = 0; m_dc_n = 0; m_eq = 0; m_to = 0; m_prev = 0; m_cause = '0;
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      return;
    end
    c = '0;
    if (sig_valid && (int'(signal_len) < int'(min_len_th) || int'(signal_len) > int'(max_len_th)))
      c[0] = 1'b1;
    s_next  = m_dc_sum + ((i_data >= 0) ? 1 : -1);
    s_abs   = (s_next < 0) ? -s_next : s_next;
    win_end = iq_valid && (m_dc_n == DC_WIN - 1);
    if (win_end && s_abs > int'(dc_th)) c[1] = 1'b1;
    if (small_eq_th != 0 && m_eq >= int'(small_eq_th)) c[2] = 1'b1;
    run = 0;
    if (state != 0 && int'(state) == m_prev) run = (m_to < CNT_MAX) ? m_to + 1 : m_to;
    if (TO_EN && timeout_th != 0 && run == int'(timeout_th)) c[3] = 1'b1;
    if (!enable) c = '0;
    fire = (m_left == 0) && power_trigger && (c != 0);
    if (fire) begin
      m_cause = c;
      m_left  = HOLD_N + BLANK_N;
      for (int k = 0; k < 4; k++) if (c[k] && m_cnt[k] < CNT_MAX) m_cnt[k]++;
    end else if (m_left > 0) begin
      m_left--;
    end
    if (cnt_clear) for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    if (!enable || fire) begin
      m_dc_sum = 0; m_dc_n = 0; m_eq = 0; m_to = 0;
    end else begin
      if (iq_valid) begin
        if (win_end) begin m_dc_sum = 0; m_dc_n = 0; end
        else begin m_dc_sum = s_next; m_dc_n++; end
      end
      if (equalizer_valid && is_small(equalizer[31:16]) && is_small(equalizer[15:0]) && m_eq < 63)
        m_eq++;
      m_to = run;
    end
    m_prev = int'(state);
  endfunction

  // One clock: the model sees the same inputs as the DUT, outputs are compared 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("model_rst",   64'(receiver_rst), 64'(m_left > BLANK_N));
    check("model_busy",  64'(busy),         64'(m_left > 0));
    check("model_cause", 64'(cause_vec),    64'(m_cause));
    check("model_cnt",   abort_cnt,         exp_cnt());
  endtask

  task automatic idle_inputs();
    enable = 1'b1; power_trigger = 1'b1; iq_valid = 1'b0; i_data = '0; q_data = '0;
    state = '0; sig_valid = 1'b0; signal_len = 16'd100; equalizer = 32'h0100_0100;
    equalizer_valid = 1'b0; min_len_th = 4'd4; max_len_th = 16'd1500; dc_th = 8'd40;
    small_eq_th = '0; timeout_th = 16'd50; cnt_clear = 1'b0;
  endtask

  task automatic clear_counters();
    cnt_clear = 1'b1; cycle(); cnt_clear = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && busy; k++) cycle();
    check("wait_idle", 64'(busy), 64'(0));
  endtask

  task automatic align_dc();
    enable = 1'b0; cycle(); enable = 1'b1;
  endtask

  int bias;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    cycle(); cycle();
    check("reset_rst",   64'(receiver_rst), 64'(0));
    check("reset_busy",  64'(busy),         64'(0));
    check("reset_cause", 64'(cause_vec),    64'(0));
    check("reset_cnt",   abort_cnt,         64'(0));
    rst_n = 1'b1;
    cycle();

    // Short SIGNAL length: two-cycle reset pulse starting the next cycle.
    clear_counters();
    sig_valid = 1'b1; signal_len = 16'd3;
    cycle();
    check("len_rst_c1", 64'(receiver_rst), 64'(1));
    sig_valid = 1'b0;
    cycle();
    check("len_rst_c2", 64'(receiver_rst), 64'(1));
    cycle();
    check("len_rst_end", 64'(receiver_rst), 64'(0));
    check("len_cause", 64'(cause_vec), 64'(4'b0001));
    check("len_cnt", 64'(abort_cnt[15:0]), 64'(1));
    // A second bad length during blanking must be ignored.
    sig_valid = 1'b1; cycle(); sig_valid = 1'b0;
    wait_idle();
    cycle();
    check("blank_ignore_rst", 64'(receiver_rst), 64'(0));
    check("blank_ignore_cnt", 64'(abort_cnt[15:0]), 64'(1));

    // Cause without power_trigger is discarded.
    power_trigger = 1'b0; sig_valid = 1'b1;
    cycle();
    check("nopwr_rst", 64'(receiver_rst), 64'(0));
    check("nopwr_cnt", 64'(abort_cnt[15:0]), 64'(1));
    power_trigger = 1'b1; sig_valid = 1'b0; signal_len = 16'd100;
    cycle();

    // Long SIGNAL length (upper bound) and the exact bound itself.
    signal_len = 16'd1500; sig_valid = 1'b1; cycle();
    check("len_at_max", 64'(busy), 64'(0));
    signal_len = 16'd1501; cycle(); sig_valid = 1'b0;
    check("len_over_max", 64'(receiver_rst), 64'(1));
    wait_idle();

    // Full DC window of positive samples.
    clear_counters();
    align_dc();
    iq_valid = 1'b1; i_data = 16'sd100;
    for (int k = 0; k < DC_WIN; k++) begin
      cycle();
      if (k == DC_WIN - 2) check("dc_quiet_63", 64'(receiver_rst), 64'(0));
      if (k == DC_WIN - 1) check("dc_rst_64", 64'(receiver_rst), 64'(1));
    end
    iq_valid = 1'b0;
    wait_idle();
    check("dc_cause", 64'(cause_vec), 64'(4'b0010));
    check("dc_cnt", 64'(abort_cnt[31:16]), 64'(1));

    // LEN and DC together: one episode, both counters incremented.
    clear_counters();
    align_dc();
    iq_valid = 1'b1;
    for (int k = 0; k < DC_WIN - 1; k++) cycle();
    sig_valid = 1'b1; signal_len = 16'd3;
    cycle();
    sig_valid = 1'b0; iq_valid = 1'b0; signal_len = 16'd100;
    check("both_rst", 64'(receiver_rst), 64'(1));
    wait_idle();
    check("both_cause", 64'(cause_vec), 64'(4'b0011));
    check("both_cnt", abort_cnt, {16'd0, 16'd0, 16'd1, 16'd1});

    // Equalizer collapse: |16| is not small, three small taps then trigger.
    small_eq_th = 6'd3; equalizer_valid = 1'b1;
    equalizer = {16'sd16, 16'sd0};   cycle(); cycle();
    equalizer = {-16'sd16, 16'sd3};  cycle(); cycle();
    check("eq_edge_quiet", 64'(busy), 64'(0));
    equalizer = {16'sd5, -16'sd15};
    cycle(); cycle(); cycle();
    equalizer_valid = 1'b0;
    cycle();
    check("eq_rst", 64'(receiver_rst), 64'(1));
    wait_idle();
    check("eq_cause", 64'(cause_vec), 64'(4'b0100));
    small_eq_th = '0;

    // Stalled receiver state.
    clear_counters();
    state = 5'd0; cycle();
    for (int k = 0; k < 100; k++) begin
      state = 5'd5;
      cycle();
      if (k == 49) check("to_quiet_49", 64'(receiver_rst), 64'(0));
      if (k == 50) check("to_rst_50", 64'(receiver_rst), 64'(TO_EN));
    end
    state = 5'd0;
    wait_idle();
    check("to_cnt", 64'(abort_cnt[63:48]), 64'(TO_EN));

    // Clear wins over a same-cycle increment.
    sig_valid = 1'b1; signal_len = 16'd2; cnt_clear = 1'b1;
    cycle();
    sig_valid = 1'b0; cnt_clear = 1'b0; signal_len = 16'd100;
    check("clr_override_rst", 64'(receiver_rst), 64'(1));
    check("clr_override_cnt", abort_cnt, 64'(0));
    wait_idle();

    // Reset in the middle of HOLD aborts the episode.
    sig_valid = 1'b1; signal_len = 16'd1;
    cycle();
    sig_valid = 1'b0; signal_len = 16'd100;
    check("midhold_rst_on", 64'(receiver_rst), 64'(1));
    rst_n = 1'b0;
    cycle();
    check("midhold_rst_off", 64'(receiver_rst), 64'(0));
    check("midhold_busy", 64'(busy), 64'(0));
    check("midhold_cnt", abort_cnt, 64'(0));
    rst_n = 1'b1;
    cycle();

    // Random traffic against the reference model.
    bias = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) begin
        bias        = $urandom_range(0, 100);
        min_len_th  = 4'($urandom_range(0, 15));
        max_len_th  = 16'($urandom_range(100, 2000));
        dc_th       = 8'($urandom_range(0, 70));
        small_eq_th = 6'($urandom_range(0, 10));
        timeout_th  = 16'($urandom_range(0, 40));
      end
      rst_n           = ($urandom_range(0, 499) != 0);
      enable          = ($urandom_range(0, 29) != 0);
      power_trigger   = ($urandom_range(0, 4) != 0);
      iq_valid        = ($urandom_range(0, 3) != 0);
      i_data          = ($urandom_range(0, 99) < bias) ? 16'($urandom_range(0, 2000))
                                                       : -16'($urandom_range(1, 2000));
      q_data          = 16'($urandom);
      sig_valid       = ($urandom_range(0, 39) == 0);
      signal_len      = 16'($urandom_range(0, 2500));
      equalizer_valid = ($urandom_range(0, 2) == 0);
      equalizer       = {16'($signed($urandom_range(0, 40)) - 16'sd20),
                         16'($signed($urandom_range(0, 40)) - 16'sd20)};
      cnt_clear       = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 59) == 0) state = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rx_abort_watchdog.md
RX_ABORT_WATCHDOG -- requirements
Module: rx_abort_watchdog

Interface
REQ-001 SHALL have parameter IQ_DATA_WIDTH, default 16, I/Q sample width.
REQ-002 SHALL have parameter DC_WIN_LOG2, default 6, DC window of 2^DC_WIN_LOG2 samples.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of per-cause abort counters.
REQ-004 SHALL have parameter RST_HOLD, default 2, receiver_rst pulse length in cycles.
REQ-005 SHALL have parameter BLANK_CYCLES, default 16, post-reset blanking interval in cycles.
REQ-006 SHALL have ports, first two: s00_axi_aclk in 1 sole clock; s00_axi_aresetn in 1 reset, synchronous, active-low.
REQ-007 SHALL have ports: enable in 1 monitor enable; power_trigger in 1 qualifies aborts; i_data, q_data in IQ_DATA_WIDTH signed samples; iq_valid in 1 sample strobe.
REQ-008 SHALL have ports: state in 5 receiver state (0 = idle); sig_valid in 1 SIGNAL decoded strobe; signal_len in 16 decoded length.
REQ-009 SHALL have ports: equalizer in 32 {I[31:16],Q[15:0]}; equalizer_valid in 1 strobe.
REQ-010 SHALL have ports: min_len_th in 4; max_len_th in 16; dc_th in 8; small_eq_th in 6; timeout_th in 16; cnt_clear in 1.
REQ-011 SHALL have outputs: receiver_rst 1; cause_vec 4 {TIMEOUT,EQ,DC,LEN} of last episode; abort_cnt 4*CNT_WIDTH packed per-cause counters, LEN in LSBs; busy 1 (FSM not IDLE).

Function
REQ-012 DC: on each iq_valid, SHALL add +1 if i_data>=0 else -1 to a (DC_WIN_LOG2+1)-bit signed sum; at window end, raise DC if |sum|>dc_th; then clear sum.
REQ-013 LEN: on sig_valid, SHALL raise LEN if signal_len<min_len_th or signal_len>max_len_th.
REQ-014 EQ: on equalizer_valid with |I|<16 and |Q|<16, SHALL increment a 6-bit saturating counter; raise EQ when counter>=small_eq_th and small_eq_th!=0; counter clears when enable is low.
REQ-015 TIMEOUT: SHALL count cycles with unchanged nonzero state; raise TIMEOUT when count==timeout_th and timeout_th!=0; count clears on state change or state==0.
REQ-016 Causes SHALL be raised only while enable=1; DC sum, EQ counter, timeout counter SHALL hold cleared while enable=0.
REQ-017 FSM states IDLE, HOLD, BLANK; IDLE->HOLD the cycle after any cause raised with power_trigger=1.
REQ-018 HOLD SHALL drive receiver_rst=1 for exactly RST_HOLD cycles, then go BLANK.
REQ-019 BLANK SHALL ignore causes for BLANK_CYCLES cycles, then return IDLE; all detectors SHALL clear on entering HOLD.
REQ-020 On IDLE->HOLD, cause_vec SHALL load all causes raised that cycle; each raised cause counter SHALL increment by one, saturating at all-ones.
REQ-021 Simultaneous causes SHALL produce one reset episode.
REQ-022 cnt_clear SHALL zero all abort counters next cycle, overriding a same-cycle increment.
REQ-023 Causes raised with power_trigger=0 SHALL be discarded without counting.

Reset
REQ-024 When s00_axi_aresetn=0 at a clock edge: receiver_rst=0, cause_vec=0, abort_cnt=0, busy=0, FSM=IDLE, all detectors cleared.
REQ-025 Reset during HOLD or BLANK SHALL abort the episode immediately, returning IDLE with receiver_rst=0.

Configuration
REQ-026 Macro RX_ABORT_WATCHDOG_TIMEOUT_EN: defined -> TIMEOUT detector per REQ-015; undefined -> no timeout logic, cause_vec[3] and TIMEOUT counter tied 0, timeout_th ignored.

Structure
REQ-027 Shared package rx_abort_watchdog_pkg SHALL hold cause bit indices, FSM state encoding, EQ small-magnitude constant 16.
REQ-028 DC detector SHALL be sub-module rx_wd_dc_monitor.

Verification
REQ-029 sig_valid, signal_len=3, min_len_th=4 -> receiver_rst high 2 cycles starting next cycle, cause_vec=4'b0001, LEN count=1.
REQ-030 64 samples with i_data=+100, dc_th=40 -> DC raised at window end, cause_vec=4'b0010.
REQ-031 state held at 5 for 100 cycles, timeout_th=50 -> TIMEOUT at cycle 50; with macro undefined, no reset.
REQ-032 LEN and DC raised in same cycle -> single episode, cause_vec=4'b0011, both counters +1.
REQ-033 Cause during BLANK, or with power_trigger=0 -> no receiver_rst, counters unchanged.
REQ-034 Reset asserted mid-HOLD -> receiver_rst=0 next edge, busy=0, counters 0.
